// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable clock divider and tick generator.
// Divides the enabled clock by N (div_value, 0 taken as 1). div_clock is high
// for the last floor(N/2) counts of each period; tick strobes on every wrap.
// A new N requested while running is held pending and only takes effect on
// a period boundary (or at once on clear / while disabled), then load_ack pulses.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   enable     in   count enable
//   clear      in   synchronous restart of the current period
//   div_value  in   [WIDTH] new divisor N
//   div_load   in   one-cycle load request for div_value
//   load_ack   out  one-cycle pulse when a new N becomes active
//   div_clock  out  divided clock (registered)
//   tick       out  one-cycle strobe per period (registered)
//   busy       out  high while a load is pending
//   count_out  out  [WIDTH] count register, only with CLK_DIV_COUNT_OUT_EN
//
// Optional feature macro: CLK_DIV_COUNT_OUT_EN
module clk_div_prog #(
  parameter int unsigned WIDTH       = 24,
  parameter int unsigned DEFAULT_DIV = 10000000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] div_value,
  input  logic             div_load,
  output logic             load_ack,
  output logic             div_clock,
  output logic             tick,
  output logic             busy
`ifdef CLK_DIV_COUNT_OUT_EN
  ,
  output logic [WIDTH-1:0] count_out
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] N_RESET = WIDTH'(DEFAULT_DIV);

  state_t           state, state_next;
  logic [WIDTH-1:0] count, count_next;
  logic [WIDTH-1:0] n_active, n_active_next;
  logic [WIDTH-1:0] n_pend, n_pend_next;
  logic             div_clock_next, tick_next, load_ack_next, busy_next;
  logic             wrap, load_req;
  logic [WIDTH-1:0] load_val, div_sane;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      count     <= '0;
      n_active  <= N_RESET;
      n_pend    <= '0;
      div_clock <= 1'b0;
      tick      <= 1'b0;
      load_ack  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      n_active  <= n_active_next;
      n_pend    <= n_pend_next;
      div_clock <= div_clock_next;
      tick      <= tick_next;
      load_ack  <= load_ack_next;
      busy      <= busy_next;
    end
  end

  always_comb begin
    state_next     = state;
    count_next     = count;
    n_active_next  = n_active;
    n_pend_next    = n_pend;
    div_clock_next = div_clock;
    tick_next      = 1'b0;
    load_ack_next  = 1'b0;
    busy_next      = busy;

    div_sane = (div_value == '0) ? ONE : div_value;
    wrap     = (count == (n_active - ONE));
    // A request on this very edge supersedes any older pending value.
    load_req = div_load || (state == PEND);
    load_val = div_load ? div_sane : n_pend;

    if (clear) begin
      count_next     = '0;
      div_clock_next = 1'b0;
      busy_next      = 1'b0;
      state_next     = enable ? RUN : IDLE;
      if (load_req) begin
        n_active_next = load_val;
        load_ack_next = 1'b1;
      end
    end else if (!enable) begin
      state_next = IDLE;
      busy_next  = 1'b0;
      // Disabling with a load pending applies it like a load while idle.
      if (load_req) begin
        n_active_next  = load_val;
        count_next     = '0;
        div_clock_next = 1'b0;
        load_ack_next  = 1'b1;
      end
    end else begin
      tick_next = wrap;
      if (wrap) begin
        count_next = '0;
        state_next = RUN;
        busy_next  = 1'b0;
        if (load_req) begin
          n_active_next = load_val;
          load_ack_next = 1'b1;
        end
      end else begin
        count_next = count + ONE;
        if (div_load) begin
          n_pend_next = div_sane;
          busy_next   = 1'b1;
          state_next  = PEND;
        end else if (state == IDLE) begin
          state_next = RUN;
        end
      end
      // Always 0 on a wrap, since the threshold ceil(N/2) is at least 1.
      div_clock_next = (count_next >= (n_active - (n_active >> 1)));
    end
  end

`ifdef CLK_DIV_COUNT_OUT_EN
  assign count_out = count;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
module tb_clk_div_prog;

  localparam int unsigned W = 8;

  logic         clock;
  logic         reset_n;
  logic         enable;
  logic         clear;
  logic [W-1:0] div_value;
  logic         div_load;
  logic         load_ack;
  logic         div_clock;
  logic         tick;
  logic         busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  clk_div_prog #(
    .WIDTH       (W),
    .DEFAULT_DIV (4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .clear     (clear),
    .div_value (div_value),
    .div_load  (div_load),
    .load_ack  (load_ack),
    .div_clock (div_clock),
    .tick      (tick),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 2 time units past it.
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic chk_out(input string tag, input logic t, input logic d, input logic a, input logic b);
    chk({tag, " tick"}, tick, t);
    chk({tag, " div_clock"}, div_clock, d);
    chk({tag, " load_ack"}, load_ack, a);
    chk({tag, " busy"}, busy, b);
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b0;
    clear     = 1'b0;
    div_value = '0;
    div_load  = 1'b0;
    #12;
    chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);

    // N=4 from reset; ticks after edges 4 and 8, div_clock 2 low / 2 high.
    reset_n = 1'b1;
    enable  = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk_out($sformatf("n4 e%0d", k), (k % 4) == 0, (k % 4) >= 2, 1'b0, 1'b0);
    end
    // Load 5 at edge 6: pending until the wrap at edge 8.
    div_value = 8'd5;
    div_load  = 1'b1;
    step();
    div_load = 1'b0;
    chk_out("load5 e6", 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    chk_out("load5 e7", 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    chk_out("load5 e8", 1'b1, 1'b0, 1'b1, 1'b0);
    // N=5: ticks at 13 and 18, div_clock 3 low / 2 high.
    for (int k = 9; k <= 18; k++) begin
      step();
      chk_out($sformatf("n5 e%0d", k), ((k - 8) % 5) == 0, ((k - 8) % 5) >= 3, 1'b0, 1'b0);
    end

    // Back to N=4 via reset, then pause 3 cycles at count=2.
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    step();
    chk_out("pause c1", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("pause c2", 1'b0, 1'b1, 1'b0, 1'b0);
    enable = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk_out($sformatf("paused %0d", k), 1'b0, 1'b1, 1'b0, 1'b0);
    end
    enable = 1'b1;
    step();
    chk_out("resume 1", 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("resume 2", 1'b1, 1'b0, 1'b0, 1'b0);

    // Idle load of 0 -> N=1: immediate ack, then tick every cycle.
    enable    = 1'b0;
    div_value = 8'd0;
    div_load  = 1'b1;
    step();
    div_load = 1'b0;
    chk_out("idle load0", 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk_out("idle hold", 1'b0, 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_out($sformatf("n1 e%0d", k), 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Idle load 6, then two loads (7, 3) before the wrap: one ack, then N=3.
    enable    = 1'b0;
    div_value = 8'd6;
    div_load  = 1'b1;
    step();
    div_load = 1'b0;
    chk_out("idle load6", 1'b0, 1'b0, 1'b1, 1'b0);
    enable = 1'b1;
    step();
    chk_out("n6 e1", 1'b0, 1'b0, 1'b0, 1'b0);
    div_value = 8'd7;
    div_load  = 1'b1;
    step();
    chk_out("dbl load7 e2", 1'b0, 1'b0, 1'b0, 1'b1);
    div_value = 8'd3;
    step();
    div_load = 1'b0;
    chk_out("dbl load3 e3", 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    chk_out("dbl e4", 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    chk_out("dbl e5", 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    chk_out("dbl wrap e6", 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk_out($sformatf("n3 e%0d", k), (k % 3) == 0, (k % 3) == 2, 1'b0, 1'b0);
    end

    // Pending load of 9 at count 2, then async reset mid-cycle discards it.
    step();
    div_value = 8'd9;
    div_load  = 1'b1;
    step();
    div_load = 1'b0;
    chk_out("pre-reset", 1'b0, 1'b1, 1'b0, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_out("async reset", 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_out($sformatf("post-reset e%0d", k), (k % 4) == 0, (k % 4) >= 2, 1'b0, 1'b0);
    end

    // clear at count 2 restarts the period.
    step();
    step();
    chk_out("pre-clear", 1'b0, 1'b1, 1'b0, 1'b0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk_out("clear", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_out($sformatf("post-clear e%0d", k), (k % 4) == 0, (k % 4) >= 2, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
